mips_muldiv_unit: RTL and testbench

Sequential multiply/divide unit that owns the architectural HI/LO registers. Executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles. Services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The ALU issues operations here and reads results back; the pipeline stalls HI/LO consumers on `busy`.

---
 rtl/mips_muldiv_pkg.sv | 19 +
 rtl/mips_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// state | meaning
// IDLE  | accepts start and MTHI/MTLO writes
// CALC  | one shift-add or restoring-divide step per cycle
// FIX   | sign correction and HI/LO writeback
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  state_e state, state_nxt;
  op_e    op_in;

  logic [CW-1:0]     count;
  logic              is_div, neg_res, neg_rem, div_zero;
  logic [XLEN-1:0]   operand, a_raw, rem;
  logic [2*XLEN-1:0] prod;

  logic              signed_in, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, shifted;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign op_in     = op_e'(op);
  assign signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg     = signed_in & a[XLEN-1];
  assign b_neg     = signed_in & b[XLEN-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // Multiply: product low half starts as the multiplier and shifts out LSB-first.
  assign add_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, operand} : '0);

  // Divide: prod low half holds the dividend, quotient bits shift in at the bottom.
  // The remainder stays below the divisor, so the truncated difference is exact when ge.
  assign shifted = {rem, prod[XLEN-1]};
  assign ge      = shifted >= {1'b0, operand};
  assign diff    = shifted[XLEN-1:0] - operand;

  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign rem_fix  = neg_rem ? -rem : rem;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      prod     <= '0;
      rem      <= '0;
      operand  <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            count    <= CW'(XLEN - 1);
            prod     <= {{XLEN{1'b0}}, mag_a};
            rem      <= '0;
            operand  <= mag_b;
            a_raw    <= a;
            is_div   <= (op_in == OP_DIV) || (op_in == OP_DIVU);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (b == '0);
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (is_div) begin
            rem  <= ge ? diff : shifted[XLEN-1:0];
            prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], ge};
          end else begin
            prod <= {add_sum, prod[XLEN-1:1]};
          end
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench: cycle-count reference model of HI/LO plus directed literal cases and random traffic.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mips_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result as {hi, lo}, straight from the instruction definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ix = $signed(x);
    iy = $signed(y);
    r  = '0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = {32'h0, x} * {32'h0, y};
      2'd2: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {32'(ix % iy), 32'(ix / iy)};
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Reference timeline: an accepted op completes 33 edges later; IDLE writes apply only while not busy.
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic        m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          m_left <= 33;
          m_res  <= model(op, a, b);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("busy", {63'h0, busy}, {63'h0, (m_left != 0)});
      chk("done", {63'h0, done}, {63'h0, m_done});
      chk("hi", {32'h0, hi}, {32'h0, m_hi});
      chk("lo", {32'h0, lo}, {32'h0, m_lo});
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input bit inject);
    int lat, nb;
    bit got;
    @(negedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; nb = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (done) got = 1;
      if (inject && lat == 10) begin
        #2; start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'h55;
      end else if (inject && lat == 11) begin
        #2; start = 1'b0; hi_we = 1'b0;
      end
    end
    chk("done_seen", {63'h0, got}, 64'd1);
    chk("latency", 64'(lat), 64'd34);
    chk("busy_cycles", 64'(nb), 64'd33);
    chk("res_hi", {32'h0, hi}, {32'h0, eh});
    chk("res_lo", {32'h0, lo}, {32'h0, el});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    chk("rst_hi", {32'h0, hi}, 64'd0);
    chk("rst_lo", {32'h0, lo}, 64'd0);
    #1 reset_n = 1'b1;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op(2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op(2'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 0);
    run_op(2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       0);
    run_op(2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1);

    @(negedge clk); #2;
    lo_we = 1'b1; wdata = 32'hAA;
    @(negedge clk); #2;
    lo_we = 1'b0;
    chk("mtlo_lo", {32'h0, lo}, 64'hAA);
    chk("mtlo_hi", {32'h0, hi}, 64'd2);

    // Reset mid-operation clears everything at once.
    @(negedge clk); #2;
    start = 1'b1; op = 2'd0; a = 32'd1234; b = 32'hFFFFFF00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'h0, busy}, 64'd0);
    chk("arst_done", {63'h0, done}, 64'd0);
    chk("arst_hi", {32'h0, hi}, 64'd0);
    chk("arst_lo", {32'h0, lo}, 64'd0);
    @(negedge clk); #2 reset_n = 1'b1;
    run_op(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    // Random traffic, including starts and writes while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      start = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      hi_we = ($urandom_range(0, 5) == 0);
      lo_we = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
    end
    @(negedge clk); #2;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
